// File: rtl/mel_fbank_acc2.sv
// mel_fbank_acc2: two-lane mel filter-bank accumulator with output FIFO.
// Each FFT magnitude bin carries one triangular weight per lane. Lane 0
// accumulates even mel bands and lane 1 odd bands. A finished band is
// clamped to WIDTH bits and written to a small first-word-fall-through FIFO.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   bin_vld/bin_ready             input bin handshake
//   bin_data, bin_w               magnitude and two packed weights (lane 1 high)
//   bin_end, bin_last             per-lane band end, last bin of frame
//   mel_vld/mel_ready             output entry handshake
//   mel_data, mel_idx, mel_sat    band energy, band index, saturation flag
//   frame_done                    pulse the cycle after bin_last is accepted
//   err_ovf, err_trunc            sticky band-overflow / truncated-frame flags
module mel_fbank_acc2 #(
   parameter int WIDTH      = 16,
   parameter int WQ         = 15,
   parameter int ACC_W      = 24,
   parameter int N_MEL      = 40,
   parameter int FIFO_DEPTH = 4,
   parameter int IDX_W      = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               bin_vld,
   output logic               bin_ready,
   input  logic [WIDTH-1:0]   bin_data,
   input  logic [2*WIDTH-1:0] bin_w,
   input  logic [1:0]         bin_end,
   input  logic               bin_last,
   output logic               mel_vld,
   input  logic               mel_ready,
   output logic [WIDTH-1:0]   mel_data,
   output logic [IDX_W-1:0]   mel_idx,
   output logic               mel_sat,
   output logic               frame_done,
   output logic               err_ovf,
   output logic               err_trunc
);
   localparam int PW    = 2 * WIDTH;
   localparam int SW    = PW + ACC_W + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 1 + IDX_W + WIDTH;
   localparam logic [SW-1:0]    ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
   localparam logic [SW-1:0]    OUT_MAX = {{(SW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
   localparam logic [IDX_W-1:0] N_MEL_I = IDX_W'(N_MEL);
   localparam logic [AW:0]      FREE2   = (AW+1)'(FIFO_DEPTH - 2);

   logic [1:0][ACC_W-1:0] acc_q, acc_d, sum;
   logic [1:0][WIDTH-1:0] res_data;
   logic [1:0]            res_sat;
   logic [IDX_W-1:0]      cnt_q, cnt_d;
   logic                  rdy_q;
   logic                  pend_q, pend_d, pend_ok_q, pend_ok_d, pend_sat_q, pend_sat_d;
   logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
   logic [WIDTH-1:0]      pend_data_q, pend_data_d;
   logic                  ovf_q, ovf_d, trunc_q, trunc_d, frame_q, frame_d;
   logic                  push, push_sat, pop, accept, first;
   logic [IDX_W-1:0]      push_idx;
   logic [WIDTH-1:0]      push_data;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q;
   logic [ENT_W-1:0]      fifo_q [FIFO_DEPTH];

   // Per-lane weighted sum, saturated to ACC_W, then clamped to WIDTH for output.
   for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [PW-1:0] prod;
      logic [SW-1:0] wide;
      logic          acc_ovf, clamp;
      assign prod        = PW'(bin_data) * PW'(bin_w[g*WIDTH +: WIDTH]);
      assign wide        = SW'(acc_q[g]) + SW'(prod >> WQ);
      assign acc_ovf     = wide > ACC_MAX;
      assign clamp       = wide > OUT_MAX;
      assign sum[g]      = acc_ovf ? ACC_MAX[ACC_W-1:0] : wide[ACC_W-1:0];
      assign res_data[g] = clamp ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
      assign res_sat[g]  = acc_ovf | clamp;
   end

   assign bin_ready  = rdy_q && !pend_q && (count_q <= FREE2);
   assign accept     = bin_vld && bin_ready;
   assign mel_vld    = (count_q != '0);
   assign pop        = mel_vld && mel_ready;
   assign {mel_sat, mel_idx, mel_data} = fifo_q[rd_ptr_q];
   assign frame_done = frame_q;
   assign err_ovf    = ovf_q;
   assign err_trunc  = trunc_q;
   // On a dual end the lane matching the counter parity goes first.
   assign first      = cnt_q[0];

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      pend_d      = 1'b0;
      pend_ok_d   = pend_ok_q;
      pend_idx_d  = pend_idx_q;
      pend_data_d = pend_data_q;
      pend_sat_d  = pend_sat_q;
      push        = 1'b0;
      push_idx    = '0;
      push_data   = '0;
      push_sat    = 1'b0;
      ovf_d       = ovf_q;
      trunc_d     = trunc_q;
      frame_d     = 1'b0;
      if (pend_q) begin
         // Second half of a dual end; its index was fixed at the accept edge
         // so a bin_last on the same bin cannot disturb it.
         push      = pend_ok_q;
         push_idx  = pend_idx_q;
         push_data = pend_data_q;
         push_sat  = pend_sat_q;
      end else if (accept) begin
         for (int i = 0; i < 2; i++) acc_d[i] = bin_end[i] ? '0 : sum[i];
         if (bin_end == 2'b11) begin
            pend_d      = 1'b1;
            pend_ok_d   = 1'b0;
            pend_idx_d  = cnt_q + IDX_W'(1);
            pend_data_d = res_data[~first];
            pend_sat_d  = res_sat[~first];
            if (cnt_q != N_MEL_I) begin
               push      = 1'b1;
               push_idx  = cnt_q;
               push_data = res_data[first];
               push_sat  = res_sat[first];
               cnt_d     = cnt_q + IDX_W'(1);
               if (cnt_q + IDX_W'(1) != N_MEL_I) begin
                  pend_ok_d = 1'b1;
                  cnt_d     = cnt_q + IDX_W'(2);
               end else begin
                  ovf_d = 1'b1;
               end
            end else begin
               ovf_d = 1'b1;
            end
         end else if (bin_end != 2'b00) begin
            if (cnt_q != N_MEL_I) begin
               push      = 1'b1;
               push_idx  = cnt_q;
               push_data = res_data[bin_end[1]];
               push_sat  = res_sat[bin_end[1]];
               cnt_d     = cnt_q + IDX_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
         if (bin_last) begin
            for (int i = 0; i < 2; i++)
               if (!bin_end[i] && sum[i] != '0) trunc_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            frame_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         rdy_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_ok_q   <= 1'b0;
         pend_idx_q  <= '0;
         pend_data_q <= '0;
         pend_sat_q  <= 1'b0;
         ovf_q       <= 1'b0;
         trunc_q     <= 1'b0;
         frame_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rdy_q       <= 1'b1;
         pend_q      <= pend_d;
         pend_ok_q   <= pend_ok_d;
         pend_idx_q  <= pend_idx_d;
         pend_data_q <= pend_data_d;
         pend_sat_q  <= pend_sat_d;
         ovf_q       <= ovf_d;
         trunc_q     <= trunc_d;
         frame_q     <= frame_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {push_sat, push_idx, push_data};
   end
endmodule

// File: tb/tb_mel_fbank_acc2.sv
module tb_mel_fbank_acc2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bin_vld = 1'b0;
   logic        bin_ready;
   logic [15:0] bin_data = '0;
   logic [31:0] bin_w = '0;
   logic [1:0]  bin_end = '0;
   logic        bin_last = 1'b0;
   logic        mel_vld;
   logic        mel_ready = 1'b1;
   logic [15:0] mel_data;
   logic [5:0]  mel_idx;
   logic        mel_sat;
   logic        frame_done, err_ovf, err_trunc;

   int total = 0;
   int bad   = 0;

   mel_fbank_acc2 dut (
      .clk(clk), .rst_n(rst_n), .bin_vld(bin_vld), .bin_ready(bin_ready),
      .bin_data(bin_data), .bin_w(bin_w), .bin_end(bin_end), .bin_last(bin_last),
      .mel_vld(mel_vld), .mel_ready(mel_ready), .mel_data(mel_data),
      .mel_idx(mel_idx), .mel_sat(mel_sat), .frame_done(frame_done),
      .err_ovf(err_ovf), .err_trunc(err_trunc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [15:0] data;
      logic        sat;
   } ent_t;
   ent_t q[$];

   // Inputs change only just after posedge, so the negedge view is what the next edge sees.
   always @(negedge clk)
      if (rst_n && mel_vld && mel_ready) q.push_back({mel_idx, mel_data, mel_sat});

   typedef struct {
      logic [15:0] d, w0, w1;
      logic [1:0]  e;
      bit          ent;
      logic [15:0] xd;
      bit          xs;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input string nm, input int idx, input int data, input int sat);
      ent_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: no entry, want idx %0d data %0d", nm, idx, data);
      end else begin
         e = q.pop_front();
         chk({nm, "_idx"}, 32'(e.idx), idx);
         chk({nm, "_data"}, 32'(e.data), data);
         chk({nm, "_sat"}, 32'(e.sat), sat);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [1:0] e, input logic l);
      int n;
      bin_data = d; bin_w = {w1, w0}; bin_end = e; bin_last = l; bin_vld = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bin_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bin_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: bin_ready got 0 want 1");
      end
      @(posedge clk); #1;
      bin_vld = 1'b0; bin_end = '0; bin_last = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while (mel_vld && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (mel_vld) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: mel_vld got 1 want 0");
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; bin_vld = 1'b0; mel_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{16'd1000,  16'h8000, 16'h0000, 2'b01, 1'b1, 16'd1000,  1'b0};
      tbl[1]  = '{16'd1000,  16'h0000, 16'h4000, 2'b10, 1'b1, 16'd500,   1'b0};
      tbl[2]  = '{16'hFFFF,  16'h8000, 16'h0000, 2'b01, 1'b1, 16'hFFFF,  1'b0};
      tbl[3]  = '{16'hFFFF,  16'h0000, 16'hFFFF, 2'b10, 1'b1, 16'hFFFF,  1'b1};
      tbl[4]  = '{16'd3,     16'h5555, 16'h0000, 2'b01, 1'b1, 16'd1,     1'b0};
      tbl[5]  = '{16'd0,     16'hFFFF, 16'hFFFF, 2'b10, 1'b1, 16'd0,     1'b0};
      tbl[6]  = '{16'd7,     16'h8000, 16'h0000, 2'b10, 1'b1, 16'd0,     1'b0};
      tbl[7]  = '{16'd1,     16'h8000, 16'h0000, 2'b01, 1'b1, 16'd8,     1'b0};
      tbl[8]  = '{16'hFFFF,  16'h8000, 16'h0000, 2'b00, 1'b0, 16'd0,     1'b0};
      tbl[9]  = '{16'd1,     16'h8000, 16'h0000, 2'b01, 1'b1, 16'hFFFF,  1'b1};
      tbl[10] = '{16'd10,    16'h0000, 16'h8000, 2'b10, 1'b1, 16'd10,    1'b0};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bin_ready", 32'(bin_ready), 0);
      chk("rst_mel_vld", 32'(mel_vld), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_err_ovf", 32'(err_ovf), 0);
      chk("rst_err_trunc", 32'(err_trunc), 0);
      rst_n = 1'b1;
      chk("rst_ready_same_cycle", 32'(bin_ready), 0);
      @(posedge clk); #1;
      chk("rst_ready_rise", 32'(bin_ready), 1);

      // single band with latency check
      send(16'd1000, 16'h4000, 16'h0, 2'b00, 1'b0);
      send(16'd1000, 16'h8000, 16'h0, 2'b00, 1'b0);
      chk("single_vld_before", 32'(mel_vld), 0);
      send(16'd1000, 16'h4000, 16'h0, 2'b01, 1'b0);
      chk("single_vld_after", 32'(mel_vld), 1);
      drain();
      pop_chk("single", 0, 2000, 0);

      // table of one-bin bands, clamp boundaries and parity mismatch
      do_reset();
      for (int i = 0; i < 11; i++) send(tbl[i].d, tbl[i].w0, tbl[i].w1, tbl[i].e, 1'b0);
      drain();
      begin
         int k;
         k = 0;
         for (int i = 0; i < 11; i++)
            if (tbl[i].ent) begin
               pop_chk($sformatf("tbl%0d", i), k, 32'(tbl[i].xd), 32'(tbl[i].xs));
               k++;
            end
      end
      chk("tbl_extra", 32'(q.size()), 0);

      // alternating bands
      do_reset();
      for (int i = 0; i < 5; i++)
         send(16'd100, 16'h8000, 16'h8000, (i == 2) ? 2'b01 : (i == 4) ? 2'b10 : 2'b00, 1'b0);
      drain();
      pop_chk("alt0", 0, 300, 0);
      pop_chk("alt1", 1, 500, 0);

      // dual end, even then odd counter
      do_reset();
      for (int i = 0; i < 4; i++)
         send(16'd100, (i % 2 == 0) ? 16'h8000 : 16'h0, (i % 2 == 1) ? 16'h8000 : 16'h0,
              (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
      send(16'd50, 16'h8000, 16'h0, 2'b00, 1'b0);
      send(16'd70, 16'h0, 16'h8000, 2'b00, 1'b0);
      send(16'd0, 16'h8000, 16'h8000, 2'b11, 1'b0);
      chk("dual_ready_low", 32'(bin_ready), 0);
      @(posedge clk); #1;
      chk("dual_ready_back", 32'(bin_ready), 1);
      send(16'd11, 16'h8000, 16'h0, 2'b01, 1'b0);
      send(16'd20, 16'h8000, 16'h0, 2'b00, 1'b0);
      send(16'd30, 16'h0, 16'h8000, 2'b00, 1'b0);
      send(16'd0, 16'h8000, 16'h8000, 2'b11, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) pop_chk($sformatf("dual_pre%0d", i), i, 100, 0);
      pop_chk("dual_even_l0", 4, 50, 0);
      pop_chk("dual_even_l1", 5, 70, 0);
      pop_chk("dual_single", 6, 11, 0);
      pop_chk("dual_odd_l1", 7, 30, 0);
      pop_chk("dual_odd_l0", 8, 20, 0);

      // accumulator saturation over 300 bins
      do_reset();
      for (int i = 0; i < 299; i++) send(16'hFFFF, 16'h8000, 16'h0, 2'b00, 1'b0);
      send(16'hFFFF, 16'h8000, 16'h0, 2'b01, 1'b0);
      drain();
      pop_chk("acc_sat", 0, 16'hFFFF, 1);

      // backpressure
      do_reset();
      mel_ready = 1'b0;
      send(16'd10, 16'h8000, 16'h0, 2'b01, 1'b0);
      chk("bp_ready1", 32'(bin_ready), 1);
      send(16'd20, 16'h0, 16'h8000, 2'b10, 1'b0);
      chk("bp_ready2", 32'(bin_ready), 1);
      send(16'd30, 16'h8000, 16'h0, 2'b01, 1'b0);
      chk("bp_ready3", 32'(bin_ready), 0);
      chk("bp_vld", 32'(mel_vld), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_hold_idx", 32'(mel_idx), 0);
      chk("bp_hold_data", 32'(mel_data), 10);
      chk("bp_hold_ready", 32'(bin_ready), 0);
      mel_ready = 1'b1;
      drain();
      pop_chk("bp0", 0, 10, 0);
      pop_chk("bp1", 1, 20, 0);
      pop_chk("bp2", 2, 30, 0);
      chk("bp_ready_after", 32'(bin_ready), 1);

      // band overflow, truncated frame, new frame
      do_reset();
      for (int i = 0; i < 41; i++) begin
         if (i == 40) chk("ovf_before", 32'(err_ovf), 0);
         send(16'(i + 1), (i % 2 == 0) ? 16'h8000 : 16'h0, (i % 2 == 1) ? 16'h8000 : 16'h0,
              (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
      end
      chk("ovf_set", 32'(err_ovf), 1);
      drain();
      for (int i = 0; i < 40; i++) pop_chk($sformatf("ovf%0d", i), i, i + 1, 0);
      chk("ovf_extra", 32'(q.size()), 0);
      send(16'd9, 16'h0, 16'h8000, 2'b00, 1'b0);
      chk("trunc_before", 32'(err_trunc), 0);
      send(16'd0, 16'h0, 16'h0, 2'b00, 1'b1);
      chk("frame_done_hi", 32'(frame_done), 1);
      chk("trunc_set", 32'(err_trunc), 1);
      @(posedge clk); #1;
      chk("frame_done_lo", 32'(frame_done), 0);
      send(16'd5, 16'h8000, 16'h0, 2'b01, 1'b0);
      drain();
      pop_chk("new_frame", 0, 5, 0);
      chk("ovf_sticky", 32'(err_ovf), 1);

      // reset mid-frame
      mel_ready = 1'b0;
      send(16'd3, 16'h8000, 16'h0, 2'b01, 1'b0);
      send(16'd4, 16'h0, 16'h8000, 2'b00, 1'b0);
      chk("mid_vld", 32'(mel_vld), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_vld", 32'(mel_vld), 0);
      chk("mid_rst_ovf", 32'(err_ovf), 0);
      chk("mid_rst_trunc", 32'(err_trunc), 0);
      chk("mid_rst_ready", 32'(bin_ready), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_ready_rise", 32'(bin_ready), 1);
      mel_ready = 1'b1;
      send(16'd6, 16'h0, 16'h8000, 2'b10, 1'b0);
      drain();
      pop_chk("mid_after", 0, 6, 0);
      chk("mid_extra", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
